hex_uart_tx: RTL and testbench

Serial output stage placed directly downstream of `counter`. It takes a 4-bit value through a valid/ready handshake, converts it to its lower-case ASCII hex digit, and transmits that character followed by a line feed (0x0A) as two 8N1 UART frames. The result is a hardware equivalent of the bench's per-value `%h` line: one line per accepted value.

---
 rtl/hex_uart_tx.sv | 109 ++++++++++
 tb/tb_hex_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_uart_tx.sv
// Prints one nibble per handshake as a lower-case ASCII hex digit plus line feed,
// sent as two back-to-back 8N1 UART frames on an idle-high line.
module hex_uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic          char_sel;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [3:0]    data;
    logic [7:0]    hex_char;
    logic [7:0]    cur_char;
    logic          bit_end;

    // Character is derived from the captured nibble, never the live input.
    always_comb begin
        hex_char = (data < 4'd10) ? {4'h3, data} : (8'h57 + {4'h0, data});
        cur_char = char_sel ? 8'h0A : hex_char;
        bit_end  = (baud == BAUD_LAST);
    end

    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;

    // tx is registered from the current state, so the line trails the state by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            char_sel <= 1'b0;
            baud     <= '0;
            bit_idx  <= '0;
            data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (in_valid) begin
                        data     <= in_data;
                        char_sel <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                DATA: begin
                    tx <= cur_char[bit_idx];
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        baud <= '0;
                        if (!char_sel) begin
                            char_sel <= 1'b1;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_uart_tx.sv
// Scoreboard bench for hex_uart_tx: accepts push expected bytes, a UART
// decoder on tx pops and compares each received frame.
module tb_hex_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic [3:0] stim_data;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       live_mode;
    logic       cnt_clr;
    logic [3:0] cnt = 4'd0;
    int         cyc = 0;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [$];
    logic [7:0] hex_tab [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                 8'h38, 8'h39, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    int live_vals [3] = '{0, 1, 2};
    int live_cnt = 0;
    int last_acc = 0;

    assign in_data = live_mode ? cnt : stim_data;

    hex_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the upstream counter: free-running 4-bit count with a clear.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        cnt <= cnt_clr ? 4'd0 : cnt + 4'd1;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Accept tracker: a negedge with valid && ready means the next rising edge accepts.
    always @(negedge clk) begin
        if (rst === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) begin
            sb.push_back(hex_tab[in_data]);
            sb.push_back(8'h0A);
            if (live_mode && live_cnt < 3) begin
                check_output("live_value", int'(in_data), live_vals[live_cnt]);
                if (live_cnt > 0) check_output("accept_spacing", cyc - last_acc, 20 * C + 1);
                live_cnt++;
            end
            last_acc = cyc;
        end
    end

    task automatic decode_frame();
        logic [7:0] b;
        logic [7:0] exp_b;
        b = 8'h00;
        repeat (C / 2) begin
            @(negedge clk);
            if (rst !== 1'b1) return;
        end
        check_output("start_bit", int'(tx), 0);
        for (int i = 0; i < 8; i++) begin
            repeat (C) begin
                @(negedge clk);
                if (rst !== 1'b1) return;
            end
            b[i] = tx;
        end
        repeat (C) begin
            @(negedge clk);
            if (rst !== 1'b1) return;
        end
        check_output("stop_bit", int'(tx), 1);
        if (sb.size() == 0) begin
            check_output("unexpected_frame", int'(b), -1);
        end else begin
            exp_b = sb.pop_front();
            check_output("frame_byte", int'(b), int'(exp_b));
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) decode_frame();
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_output(name, int'(n < 400), 1);
    endtask

    task automatic apply_stimulus(input logic [3:0] nib, input logic change, input logic [3:0] late);
        int n;
        @(posedge clk);
        #1;
        stim_data = nib;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (change) stim_data = late;
        n = 0;
        @(negedge clk);
        check_output("pre_start_tx", int'(tx), 1);
        if (busy) n++;
        @(negedge clk);
        check_output("start_latency", int'(tx), 0);
        if (busy) n++;
        while (busy && n < 200) begin
            @(negedge clk);
            if (busy) n++;
        end
        check_output("busy_cycles", n, 20 * C);
        wait_drain("drain");
    endtask

    initial begin : stimulus
        rst       = 1'b0;
        in_valid  = 1'b0;
        stim_data = 4'h0;
        live_mode = 1'b0;
        cnt_clr   = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("reset_tx", int'(tx), 1);
            check_output("reset_ready", int'(in_ready), 1);
            check_output("reset_busy", int'(busy), 0);
            in_valid = ~in_valid;
        end
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_output("post_reset_tx", int'(tx), 1);
        check_output("post_reset_ready", int'(in_ready), 1);

        apply_stimulus(4'h3, 1'b0, 4'h0);
        apply_stimulus(4'h9, 1'b1, 4'hF);
        apply_stimulus(4'hA, 1'b0, 4'h0);
        apply_stimulus(4'hF, 1'b1, 4'h1);

        // Live counter feed with in_valid held high for three accepts.
        @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr   = 1'b0;
        live_mode = 1'b1;
        in_valid  = 1'b1;
        begin
            int n;
            n = 0;
            while (live_cnt < 3 && n < 400) begin
                @(negedge clk);
                n++;
            end
            check_output("live_accepts", live_cnt, 3);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        live_mode = 1'b0;
        wait_drain("live_drain");

        // Reset during data bit 2 of the '3' frame (a low bit).
        @(posedge clk);
        #1;
        stim_data = 4'h3;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (13) @(posedge clk);
        #3;
        check_output("pre_reset_tx", int'(tx), 0);
        rst = 1'b0;
        #1;
        check_output("midreset_tx", int'(tx), 1);
        check_output("midreset_ready", int'(in_ready), 1);
        check_output("midreset_busy", int'(busy), 0);
        sb.delete();
        repeat (2) begin
            @(negedge clk);
            check_output("midreset_hold_tx", int'(tx), 1);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("post_abort_idle", int'(tx), 1);
        end
        apply_stimulus(4'h5, 1'b0, 4'h0);

        repeat (5) @(negedge clk);
        check_output("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule
